// File: rtl/clk_div_monitor_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package clk_div_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_CHECK = 2'd2,
        ST_LOCK  = 2'd3
    } chk_state_e;

    localparam int unsigned LOCK_EDGES_DEF = 4;
    localparam int unsigned GOOD_W         = 4;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2_u(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = 32'(i) + 1;
            end
        end
        return r;
    endfunction

    // Largest of three values.
    function automatic int unsigned max3_u(input int unsigned a, input int unsigned b,
                                           input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Monitor-side signal bundle: enable and clocks under test in, status out.
interface clk_div_monitor_if #(
    parameter int unsigned ERRW = 8
);
    logic            enb;
    logic            clk10_in;
    logic            clk20_in;
    logic            clk40_in;
    logic [2:0]      lock;
    logic [2:0]      err;
    logic            all_lock;
    logic [ERRW-1:0] err_cnt;

    // Driver side (clock generator / bench)
    modport master (
        output enb, clk10_in, clk20_in, clk40_in,
        input  lock, err, all_lock, err_cnt
    );

    // Monitor side
    modport slave (
        input  enb, clk10_in, clk20_in, clk40_in,
        output lock, err, all_lock, err_cnt
    );
endinterface

// File: rtl/clk_div_monitor_checker.sv
// Single-channel period checker: tracks toggle spacing of one divided clock.
module clk_period_checker
    import clk_div_monitor_pkg::*;
#(
    parameter int unsigned HALF       = 1,
    parameter int unsigned LOCK_EDGES = LOCK_EDGES_DEF,
    parameter int unsigned CNTW       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enb_i,
    input  logic clk_in_i,
    output logic lock_o,
    output logic err_o
);

    localparam logic [CNTW-1:0]   HALF_C   = CNTW'(HALF);
    localparam logic [CNTW-1:0]   CNT_MAX  = '1;
    localparam logic [GOOD_W-1:0] GOOD_MAX = '1;
    localparam logic [GOOD_W-1:0] LE_C     = GOOD_W'(LOCK_EDGES);

    chk_state_e        state_q;
    logic              prev_q;
    logic [CNTW-1:0]   cnt_q;
    logic [GOOD_W-1:0] good_q;
    logic              lock_q;
    logic              err_q;

    logic              edge_c;
    logic [CNTW-1:0]   cnt_inc_c;
    logic [GOOD_W-1:0] good_inc_c;

    // Edge detect and saturating increments
    assign edge_c     = clk_in_i ^ prev_q;
    assign cnt_inc_c  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNTW'(1);
    assign good_inc_c = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);

    // Channel FSM with registered lock/err
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            good_q  <= '0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            prev_q <= clk_in_i;
            err_q  <= 1'b0;
            if (!enb_i) begin
                state_q <= ST_IDLE;
                lock_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ACQ;
                        lock_q  <= 1'b0;
                    end
                    ST_ACQ: begin
                        lock_q <= 1'b0;
                        if (edge_c) begin
                            cnt_q   <= CNTW'(1);
                            good_q  <= '0;
                            state_q <= ST_CHECK;
                        end
                    end
                    ST_CHECK, ST_LOCK: begin
                        if (edge_c && (cnt_q == HALF_C)) begin
                            cnt_q  <= CNTW'(1);
                            good_q <= good_inc_c;
                            if ((state_q == ST_CHECK) && (good_inc_c == LE_C)) begin
                                state_q <= ST_LOCK;
                                lock_q  <= 1'b1;
                            end
                        end else if (edge_c || (cnt_q == HALF_C)) begin
                            // Early edge or missing edge: drop lock and re-acquire
                            err_q   <= 1'b1;
                            lock_q  <= 1'b0;
                            state_q <= ST_ACQ;
                        end else begin
                            cnt_q <= cnt_inc_c;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        lock_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign lock_o = lock_q;
    assign err_o  = err_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: three period checkers, combined lock and error count.
module clk_div_monitor
    import clk_div_monitor_pkg::*;
#(
    parameter int unsigned HALF10     = 1,
    parameter int unsigned HALF20     = 2,
    parameter int unsigned HALF40     = 4,
    parameter int unsigned LOCK_EDGES = LOCK_EDGES_DEF,
    parameter int unsigned ERRW       = 8
) (
    input  logic             clk,
    input  logic             rst,
    clk_div_monitor_if.slave mon
);

    localparam int unsigned CNTW = clog2_u(max3_u(HALF10, HALF20, HALF40)) + 2;
    localparam int unsigned SUMW = ERRW + 1;

    logic [2:0]      lock_s;
    logic [2:0]      err_s;
    logic            all_lock_q;
    logic [ERRW-1:0] err_cnt_q;
    logic [1:0]      err_pop_c;
    logic [SUMW-1:0] err_sum_c;
    logic [ERRW-1:0] err_cnt_sat_c;

    clk_period_checker #(.HALF(HALF10), .LOCK_EDGES(LOCK_EDGES), .CNTW(CNTW)) u_chk10 (
        .clk(clk), .rst(rst), .enb_i(mon.enb), .clk_in_i(mon.clk10_in),
        .lock_o(lock_s[0]), .err_o(err_s[0])
    );

    clk_period_checker #(.HALF(HALF20), .LOCK_EDGES(LOCK_EDGES), .CNTW(CNTW)) u_chk20 (
        .clk(clk), .rst(rst), .enb_i(mon.enb), .clk_in_i(mon.clk20_in),
        .lock_o(lock_s[1]), .err_o(err_s[1])
    );

    clk_period_checker #(.HALF(HALF40), .LOCK_EDGES(LOCK_EDGES), .CNTW(CNTW)) u_chk40 (
        .clk(clk), .rst(rst), .enb_i(mon.enb), .clk_in_i(mon.clk40_in),
        .lock_o(lock_s[2]), .err_o(err_s[2])
    );

    // Saturating add of this cycle's error pulses; at most 3 so only the carry matters
    assign err_pop_c     = 2'(err_s[0]) + 2'(err_s[1]) + 2'(err_s[2]);
    assign err_sum_c     = {1'b0, err_cnt_q} + SUMW'(err_pop_c);
    assign err_cnt_sat_c = err_sum_c[ERRW] ? '1 : err_sum_c[ERRW-1:0];

    // Combined lock stage and error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            all_lock_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            all_lock_q <= &lock_s;
            if (mon.enb) begin
                err_cnt_q <= err_cnt_sat_c;
            end
        end
    end

    assign mon.lock     = lock_s;
    assign mon.err      = err_s;
    assign mon.all_lock = all_lock_q;
    assign mon.err_cnt  = err_cnt_q;

endmodule
